// File: rtl/macpu_mem_bridge.sv
// macpu_mem_bridge: MACPU external bus to req/ack memory port bridge.
// Optional abort-on-timeout: define MACPU_MEM_BRIDGE_TIMEOUT_EN.
module macpu_mem_bridge #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter int                TIMEOUT = 255,
    parameter logic [DATA_W-1:0] TO_DATA = DATA_W'(16'hFFFF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock_in,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rdata_oe,
    output logic              cpu_lock_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

`ifdef MACPU_MEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;

    // Last waiting REQ cycle: the count reaches TIMEOUT at this edge.
    assign to_hit = (to_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_cfg;

    // Timeout parameters have no role without the abort logic.
    assign unused_cfg = ^{TO_DATA, TIMEOUT[0]};
    assign err        = 1'b0;
`endif

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rdata    <= '0;
            cpu_rdata_oe <= 1'b0;
            cpu_lock_out <= 1'b0;
            busy         <= 1'b0;
`ifdef MACPU_MEM_BRIDGE_TIMEOUT_EN
            to_cnt       <= '0;
            err          <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (!cpu_lock_in) begin
                        state        <= REQ;
                        mem_req      <= 1'b1;
                        cpu_lock_out <= 1'b1;
                        busy         <= 1'b1;
                        mem_we       <= cpu_rw;
                        mem_addr     <= cpu_addr;
                        mem_wdata    <= cpu_wdata;
`ifdef MACPU_MEM_BRIDGE_TIMEOUT_EN
                        to_cnt       <= '0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state        <= RESP;
                        mem_req      <= 1'b0;
                        cpu_lock_out <= 1'b0;
                        cpu_rdata_oe <= !mem_we;
                        if (!mem_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
`ifdef MACPU_MEM_BRIDGE_TIMEOUT_EN
                    else if (to_hit) begin
                        state        <= RESP;
                        mem_req      <= 1'b0;
                        cpu_lock_out <= 1'b0;
                        cpu_rdata_oe <= !mem_we;
                        err          <= 1'b1;
                        if (!mem_we) begin
                            cpu_rdata <= TO_DATA;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state        <= IDLE;
                    cpu_rdata_oe <= 1'b0;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macpu_mem_bridge.sv
// tb_macpu_mem_bridge: directed self-checking bench for macpu_mem_bridge.
// Timeout steps run only when MACPU_MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_macpu_mem_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_lock_in;
    logic [15:0] cpu_rdata;
    logic        cpu_rdata_oe;
    logic        cpu_lock_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    macpu_mem_bridge #(
        .ADDR_W (16),
        .DATA_W (16),
        .TIMEOUT(4),
        .TO_DATA(16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_lock_in (cpu_lock_in),
        .cpu_rdata   (cpu_rdata),
        .cpu_rdata_oe(cpu_rdata_oe),
        .cpu_lock_out(cpu_lock_out),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"},  32'(mem_req),      32'h0);
        chk({tag, ".mem_we"},   32'(mem_we),       32'h0);
        chk({tag, ".mem_addr"}, 32'(mem_addr),     32'h0);
        chk({tag, ".mem_wd"},   32'(mem_wdata),    32'h0);
        chk({tag, ".rdata"},    32'(cpu_rdata),    32'h0);
        chk({tag, ".oe"},       32'(cpu_rdata_oe), 32'h0);
        chk({tag, ".lock"},     32'(cpu_lock_out), 32'h0);
        chk({tag, ".busy"},     32'(busy),         32'h0);
        chk({tag, ".err"},      32'(err),          32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        cpu_rw      = 1'b0;
        cpu_addr    = 16'h0;
        cpu_wdata   = 16'h0;
        cpu_lock_in = 1'b1;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Lock held: bridge stays idle.
        cpu_addr = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("locked.req",  32'(mem_req), 32'h0);
            chk("locked.busy", 32'(busy),    32'h0);
        end

        // Read, ack in first REQ cycle.
        cpu_addr    = 16'h1234;
        cpu_rw      = 1'b0;
        cpu_lock_in = 1'b0;
        tick();
        chk("rd.req",  32'(mem_req),      32'h1);
        chk("rd.lock", 32'(cpu_lock_out), 32'h1);
        chk("rd.we",   32'(mem_we),       32'h0);
        chk("rd.addr", 32'(mem_addr),     32'h1234);
        chk("rd.busy", 32'(busy),         32'h1);
        chk("rd.oe0",  32'(cpu_rdata_oe), 32'h0);
        cpu_lock_in = 1'b1;
        mem_ack     = 1'b1;
        mem_rdata   = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("rd.resp.req",  32'(mem_req),      32'h0);
        chk("rd.resp.lock", 32'(cpu_lock_out), 32'h0);
        chk("rd.resp.data", 32'(cpu_rdata),    32'hBEEF);
        chk("rd.resp.oe",   32'(cpu_rdata_oe), 32'h1);
        chk("rd.resp.busy", 32'(busy),         32'h1);
        tick();
        chk("rd.idle.oe",   32'(cpu_rdata_oe), 32'h0);
        chk("rd.idle.busy", 32'(busy),         32'h0);

        // Write, 4 wait cycles; CPU inputs change mid-transaction.
        cpu_addr    = 16'h00F0;
        cpu_wdata   = 16'h5A5A;
        cpu_rw      = 1'b1;
        cpu_lock_in = 1'b0;
        tick();
        cpu_lock_in = 1'b1;
        cpu_addr    = 16'hFFFF;
        cpu_wdata   = 16'h0000;
        cpu_rw      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wr.req",  32'(mem_req),      32'h1);
            chk("wr.lock", 32'(cpu_lock_out), 32'h1);
            chk("wr.we",   32'(mem_we),       32'h1);
            chk("wr.addr", 32'(mem_addr),     32'h00F0);
            chk("wr.data", 32'(mem_wdata),    32'h5A5A);
            chk("wr.oe",   32'(cpu_rdata_oe), 32'h0);
            if (i == 4) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'h1111;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("wr.resp.req",  32'(mem_req),      32'h0);
        chk("wr.resp.lock", 32'(cpu_lock_out), 32'h0);
        chk("wr.resp.oe",   32'(cpu_rdata_oe), 32'h0);
        chk("wr.resp.busy", 32'(busy),         32'h1);
        chk("wr.resp.data", 32'(cpu_rdata),    32'hBEEF);
        tick();
        chk("wr.idle.busy", 32'(busy),         32'h0);
        chk("wr.idle.oe",   32'(cpu_rdata_oe), 32'h0);

        // Stray ack while idle.
        mem_ack   = 1'b1;
        mem_rdata = 16'h2222;
        tick();
        mem_ack = 1'b0;
        chk("stray.req",   32'(mem_req),      32'h0);
        chk("stray.busy",  32'(busy),         32'h0);
        chk("stray.oe",    32'(cpu_rdata_oe), 32'h0);
        chk("stray.rdata", 32'(cpu_rdata),    32'hBEEF);
        chk("stray.addr",  32'(mem_addr),     32'h00F0);

        // Reset during second REQ cycle.
        cpu_addr    = 16'h3344;
        cpu_rw      = 1'b0;
        cpu_lock_in = 1'b0;
        tick();
        cpu_lock_in = 1'b1;
        tick();
        chk("rstmid.req2",  32'(mem_req),  32'h1);
        chk("rstmid.addr2", 32'(mem_addr), 32'h3344);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rstmid");
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        chk("rstmid.late.busy",  32'(busy),         32'h0);
        chk("rstmid.late.oe",    32'(cpu_rdata_oe), 32'h0);
        chk("rstmid.late.rdata", 32'(cpu_rdata),    32'h0);

`ifdef MACPU_MEM_BRIDGE_TIMEOUT_EN
        // No ack: abort after 4 REQ cycles.
        cpu_addr    = 16'h4000;
        cpu_rw      = 1'b0;
        cpu_lock_in = 1'b0;
        tick();
        cpu_lock_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("to.req", 32'(mem_req), 32'h1);
            chk("to.err", 32'(err),     32'h0);
            tick();
        end
        chk("to.resp.req",   32'(mem_req),      32'h0);
        chk("to.resp.lock",  32'(cpu_lock_out), 32'h0);
        chk("to.resp.err",   32'(err),          32'h1);
        chk("to.resp.rdata", 32'(cpu_rdata),    32'hFFFF);
        chk("to.resp.oe",    32'(cpu_rdata_oe), 32'h1);
        tick();
        chk("to.idle.oe", 32'(cpu_rdata_oe), 32'h0);
        // Following acked read completes normally; err stays set.
        cpu_addr    = 16'h4444;
        cpu_lock_in = 1'b0;
        tick();
        cpu_lock_in = 1'b1;
        mem_ack     = 1'b1;
        mem_rdata   = 16'hABCD;
        tick();
        mem_ack = 1'b0;
        chk("to2.rdata", 32'(cpu_rdata),    32'hABCD);
        chk("to2.oe",    32'(cpu_rdata_oe), 32'h1);
        chk("to2.err",   32'(err),          32'h1);
        tick();
`else
        // No timeout: REQ waits indefinitely, err stays 0.
        cpu_addr    = 16'h4000;
        cpu_rw      = 1'b0;
        cpu_lock_in = 1'b0;
        tick();
        cpu_lock_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("wait.req", 32'(mem_req), 32'h1);
            chk("wait.err", 32'(err),     32'h0);
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hABCD;
        tick();
        mem_ack = 1'b0;
        chk("wait.rdata", 32'(cpu_rdata),    32'hABCD);
        chk("wait.oe",    32'(cpu_rdata_oe), 32'h1);
        chk("wait.err",   32'(err),          32'h0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/macpu_mem_bridge.md
# macpu_mem_bridge

Downstream bus bridge between the MACPU core's external bus (address, rw, data and lock lines) and a synchronous memory/peripheral port with a request/acknowledge handshake. Each unlocked CPU bus cycle becomes one memory transaction. The bridge drives the shared lock line high to stall the core while the transaction is outstanding, then returns read data on the CPU data bus for one cycle. The top level owns the tri-state resolution; this block uses split in/out/enable signals only.

## Interface
- `ADDR_W`, 16, address width (matches core `o_addr`)
- `DATA_W`, 16, data width (matches core `io_data`)
- `TIMEOUT`, 255, maximum REQ cycles before abort (used only with timeout macro)
- `TO_DATA`, 16'hFFFF, read data returned on timeout abort

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: **synchronous, active-high** reset
- `cpu_rw` in 1: 0 = read, 1 = write (core convention)
- `cpu_addr` in ADDR_W: CPU address
- `cpu_wdata` in DATA_W: CPU write data (core data bus when `cpu_rw`=1)
- `cpu_lock_in` in 1: resolved lock line; 1 = bus held, no new access
- `cpu_rdata` out DATA_W: read data toward core data bus
- `cpu_rdata_oe` out 1: drive enable for `cpu_rdata`
- `cpu_lock_out` out 1: bridge drives lock line high (stall core)
- `mem_req` out 1: transaction request, held until ack
- `mem_we` out 1: 1 = write
- `mem_addr` out ADDR_W: transaction address
- `mem_wdata` out DATA_W: write data
- `mem_ack` in 1: one-cycle acknowledge; `mem_rdata` valid the same cycle
- `mem_rdata` in DATA_W: read data
- `busy` out 1: state != IDLE
- `err` out 1: sticky timeout flag (0 when macro absent)

## Operation
- States: IDLE, REQ, RESP.
- IDLE: if `cpu_lock_in`=0, latch `cpu_addr`, `cpu_rw`, `cpu_wdata` into `mem_addr`, `mem_we`, `mem_wdata` and go to REQ. Otherwise stay in IDLE.
- REQ: `mem_req`=1 and `cpu_lock_out`=1.
  - On `mem_ack`: capture `mem_rdata` into `cpu_rdata` if read, then go to RESP.
  - `mem_we`/`mem_addr`/`mem_wdata` are stable throughout REQ.
- RESP: `mem_req`=0, `cpu_lock_out`=0.
  - `cpu_rdata_oe`=1 only if the transaction was a read; writes leave `cpu_rdata_oe`=0.
  - Always returns to IDLE next cycle.
- CPU inputs are ignored outside IDLE; changes mid-transaction have no effect.
- `cpu_lock_in` high in REQ (the bridge's own lock, or an external lock) does not abort the transaction.
- `mem_ack` in IDLE or RESP is ignored.
- `cpu_rdata` holds its last captured value; it is only meaningful while `cpu_rdata_oe`=1.

## Timing
- All outputs are registered.
- Reset values: every output is 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_rdata`, `cpu_rdata_oe`, `cpu_lock_out`, `busy`, `err`); state = IDLE.
- Reset mid-transaction: `mem_req` and `cpu_lock_out` are low on the cycle after the `rst` edge; the abandoned `mem_ack` is ignored.
- Latency, with IDLE acceptance at edge T:
  - REQ outputs visible T+1.
  - Ack at cycle T+1+k (k≥0) gives RESP at T+2+k; back in IDLE at T+3+k.
  - Minimum transaction is 3 cycles; a new access can be accepted at the edge ending the IDLE cycle.
- `cpu_lock_out` is high for exactly the REQ cycles (k+1).
- `cpu_rdata_oe` is a single-cycle pulse per read.
- `busy` is high in REQ and RESP.

## Configuration
- Macro: `MACPU_MEM_BRIDGE_TIMEOUT_EN`.
- Defined:
  - An 8-bit+ counter clears on REQ entry and increments each REQ cycle without `mem_ack`.
  - When the count reaches `TIMEOUT` with no ack, drop `mem_req`, set `err`=1 (sticky until `rst`) and enter RESP.
  - A read returns `TO_DATA`.
  - Ack on the same cycle as expiry wins: normal completion, no error.
- Undefined: REQ waits indefinitely; `err` is tied to 0; no counter logic.

## Test plan
- Reset, then `cpu_lock_in`=1 held -> all outputs 0, state stays IDLE, `mem_req` never rises.
- Read: `cpu_addr`=16'h1234, `cpu_rw`=0, ack with `mem_rdata`=16'hBEEF on the first REQ cycle -> `mem_req`/`cpu_lock_out` high for 1 cycle, then `cpu_rdata`=16'hBEEF with `cpu_rdata_oe`=1 for 1 cycle, 3 cycles total.
- Write: `cpu_addr`=16'h00F0, `cpu_wdata`=16'h5A5A, ack after 4 wait cycles -> `mem_we`=1, address and data stable for 5 REQ cycles, lock high 5 cycles, `cpu_rdata_oe` never asserted.
- Change `cpu_addr`/`cpu_rw` during REQ, and pulse `mem_ack` in IDLE -> `mem_addr` and `mem_we` unchanged, stray ack ignored.
- `rst` asserted in the 2nd REQ cycle -> next cycle all outputs 0 and IDLE; a later ack has no effect.
- With `MACPU_MEM_BRIDGE_TIMEOUT_EN`, `TIMEOUT`=4, no ack on a read -> after 4 REQ cycles `err`=1 and `cpu_rdata`=16'hFFFF with OE pulse. A following acked transaction completes normally with `err` still 1.
